// File: rtl/elevator_door_controller.sv
// Door-operator sequencer: drives the door motor from the limit and obstruction sensors, times the
// open dwell, reopens on obstruction with a bounded nudge mode, and supervises travel and sensor faults.
module elevator_door_controller #(
    parameter int DWELL_CYCLES   = 50,
    parameter int TRAVEL_TIMEOUT = 20,
    parameter int MAX_REOPEN     = 3,
    parameter int CNT_W          = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       door_open_req,
    input  logic       door_open_btn,
    input  logic       door_close_btn,
    input  logic       elevator_moving,
    input  logic       emergency_stop,
    input  logic       open_limit,
    input  logic       closed_limit,
    input  logic       obstruction,
    input  logic       fault_clear,
    output logic       motor_open,
    output logic       motor_close,
    output logic       nudge,
    output logic       door_closed_ok,
    output logic       door_fault,
    output logic [2:0] door_state
);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam int RC_W = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);
    localparam logic [RC_W-1:0]  REOPEN_MAX  = RC_W'(MAX_REOPEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] travel_q, travel_d;
    logic [RC_W-1:0]  reopen_q, reopen_d;
    logic             nudge_mode_q, nudge_mode_d;
    logic             motor_open_q, motor_open_d;
    logic             motor_close_q, motor_close_d;
    logic             nudge_out_q, nudge_out_d;
    logic             door_fault_q, door_fault_d;
    logic             frozen_s;
    logic             paused_s;
    logic             reload_s;

    // Next-state, counter and output-flop computation with the global priority chain on top.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        travel_d     = travel_q;
        reopen_d     = reopen_q;
        nudge_mode_d = nudge_mode_q;
        frozen_s     = 1'b0;
        paused_s     = 1'b0;
        reload_s     = 1'b0;

        if (open_limit && closed_limit) begin
            state_d = ST_FAULT;
        end else if (elevator_moving && (state_q != ST_CLOSED) && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
        end else if (emergency_stop) begin
            frozen_s = 1'b1;
        end else begin
            case (state_q)
                ST_CLOSED: begin
                    if ((door_open_req || door_open_btn) && !elevator_moving) begin
                        state_d  = ST_OPENING;
                        travel_d = '0;
                    end else begin
                        state_d = ST_CLOSED;
                    end
                end
                ST_OPENING: begin
                    if (open_limit) begin
                        state_d = ST_OPEN;
                        dwell_d = DWELL_LOAD;
                    end else if (travel_q == TRAVEL_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        travel_d = travel_q + CNT_W'(1);
                    end
                end
                ST_OPEN: begin
                    // In nudge mode only the light curtain may extend the dwell.
                    reload_s = obstruction || (door_open_btn && !nudge_mode_q);
                    if (reload_s) begin
                        dwell_d = DWELL_LOAD;
                    end else if (dwell_q == '0) begin
                        if (!door_open_req) begin
                            state_d      = ST_CLOSING;
                            travel_d     = '0;
                            nudge_mode_d = (reopen_q >= REOPEN_MAX);
                        end else begin
                            dwell_d = '0;
                        end
                    end else if (door_close_btn) begin
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q - CNT_W'(1);
                    end
                end
                ST_CLOSING: begin
                    if (closed_limit) begin
                        state_d      = ST_CLOSED;
                        reopen_d     = '0;
                        nudge_mode_d = 1'b0;
                    end else if (nudge_mode_q && obstruction) begin
                        paused_s = 1'b1;
                    end else if (!nudge_mode_q && (obstruction || door_open_btn || door_open_req)) begin
                        state_d  = ST_OPENING;
                        travel_d = '0;
                        if (reopen_q < REOPEN_MAX) begin
                            reopen_d = reopen_q + RC_W'(1);
                        end else begin
                            reopen_d = reopen_q;
                        end
                    end else if (travel_q == TRAVEL_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        travel_d = travel_q + CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (fault_clear && closed_limit) begin
                        state_d      = ST_CLOSED;
                        reopen_d     = '0;
                        nudge_mode_d = 1'b0;
                    end else if (fault_clear) begin
                        state_d      = ST_CLOSING;
                        travel_d     = '0;
                        nudge_mode_d = (reopen_q >= REOPEN_MAX);
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end

        motor_open_d  = (state_d == ST_OPENING) && !frozen_s;
        motor_close_d = (state_d == ST_CLOSING) && !frozen_s && !paused_s;
        nudge_out_d   = nudge_mode_d && (state_d == ST_CLOSING);
        door_fault_d  = (state_d == ST_FAULT);
    end

    // State, counters and output flops; reset drops the motors without waiting for a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_CLOSED;
            dwell_q       <= '0;
            travel_q      <= '0;
            reopen_q      <= '0;
            nudge_mode_q  <= 1'b0;
            motor_open_q  <= 1'b0;
            motor_close_q <= 1'b0;
            nudge_out_q   <= 1'b0;
            door_fault_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            travel_q      <= travel_d;
            reopen_q      <= reopen_d;
            nudge_mode_q  <= nudge_mode_d;
            motor_open_q  <= motor_open_d;
            motor_close_q <= motor_close_d;
            nudge_out_q   <= nudge_out_d;
            door_fault_q  <= door_fault_d;
        end
    end

    assign motor_open     = motor_open_q;
    assign motor_close    = motor_close_q;
    assign nudge          = nudge_out_q;
    assign door_fault     = door_fault_q;
    assign door_state     = state_q;
    assign door_closed_ok = (state_q == ST_CLOSED) && closed_limit;

endmodule

// File: tb/tb_elevator_door_controller.sv
// Directed bench for elevator_door_controller with DWELL_CYCLES=8, TRAVEL_TIMEOUT=6, MAX_REOPEN=2.
module tb_elevator_door_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       door_open_req, door_open_btn, door_close_btn;
    logic       elevator_moving, emergency_stop;
    logic       open_limit, closed_limit, obstruction, fault_clear;
    logic       motor_open, motor_close, nudge, door_closed_ok, door_fault;
    logic [2:0] door_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    elevator_door_controller #(
        .DWELL_CYCLES  (8),
        .TRAVEL_TIMEOUT(6),
        .MAX_REOPEN    (2),
        .CNT_W         (8)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .door_open_req  (door_open_req),
        .door_open_btn  (door_open_btn),
        .door_close_btn (door_close_btn),
        .elevator_moving(elevator_moving),
        .emergency_stop (emergency_stop),
        .open_limit     (open_limit),
        .closed_limit   (closed_limit),
        .obstruction    (obstruction),
        .fault_clear    (fault_clear),
        .motor_open     (motor_open),
        .motor_close    (motor_close),
        .nudge          (nudge),
        .door_closed_ok (door_closed_ok),
        .door_fault     (door_fault),
        .door_state     (door_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; door_open_req = 1'b0; door_open_btn = 1'b0; door_close_btn = 1'b0;
        elevator_moving = 1'b0; emergency_stop = 1'b0; open_limit = 1'b0; closed_limit = 1'b1;
        obstruction = 1'b0; fault_clear = 1'b0;
        tick(); tick();
        check("rst_state", 8'(door_state), 8'd0);
        check("rst_motor_open", 8'(motor_open), 8'd0);
        check("rst_motor_close", 8'(motor_close), 8'd0);
        check("rst_nudge", 8'(nudge), 8'd0);
        check("rst_fault", 8'(door_fault), 8'd0);
        check("rst_closed_ok", 8'(door_closed_ok), 8'd1);
        reset_n = 1'b1;
        tick();

        // request while moving is ignored
        elevator_moving = 1'b1; door_open_req = 1'b1;
        tick();
        check("moving_ignore_state", 8'(door_state), 8'd0);
        elevator_moving = 1'b0; door_open_req = 1'b0;
        tick();

        // nominal cycle
        door_open_req = 1'b1;
        tick();
        check("nom_opening", 8'(door_state), 8'd1);
        check("nom_motor_open1", 8'(motor_open), 8'd1);
        check("nom_closed_ok_low", 8'(door_closed_ok), 8'd0);
        door_open_req = 1'b0; closed_limit = 1'b0;
        tick(); tick();
        check("nom_motor_open3", 8'(motor_open), 8'd1);
        open_limit = 1'b1;
        tick();
        check("nom_open", 8'(door_state), 8'd2);
        check("nom_motor_open_off", 8'(motor_open), 8'd0);
        repeat (7) tick();
        check("nom_open_last", 8'(door_state), 8'd2);
        tick();
        check("nom_closing", 8'(door_state), 8'd3);
        check("nom_motor_close", 8'(motor_close), 8'd1);
        open_limit = 1'b0;
        tick();
        closed_limit = 1'b1;
        tick();
        check("nom_closed", 8'(door_state), 8'd0);
        check("nom_closed_ok", 8'(door_closed_ok), 8'd1);
        check("nom_motor_close_off", 8'(motor_close), 8'd0);

        // dwell reload by open button at count 2
        door_open_req = 1'b1;
        tick();
        door_open_req = 1'b0; closed_limit = 1'b0; open_limit = 1'b1;
        tick();
        repeat (5) tick();
        door_open_btn = 1'b1;
        tick();
        door_open_btn = 1'b0;
        repeat (7) tick();
        check("dwell_reload_open", 8'(door_state), 8'd2);
        tick();
        check("dwell_reload_closing", 8'(door_state), 8'd3);
        open_limit = 1'b0; closed_limit = 1'b1;
        tick();
        check("dwell_closed", 8'(door_state), 8'd0);

        // close button cuts the dwell
        door_open_req = 1'b1;
        tick();
        door_open_req = 1'b0; closed_limit = 1'b0; open_limit = 1'b1;
        tick(); tick();
        door_close_btn = 1'b1;
        tick();
        door_close_btn = 1'b0;
        check("close_btn_still_open", 8'(door_state), 8'd2);
        tick();
        check("close_btn_closing", 8'(door_state), 8'd3);
        open_limit = 1'b0; closed_limit = 1'b1;
        tick();

        // travel timeout in OPENING
        door_open_req = 1'b1;
        tick();
        door_open_req = 1'b0; closed_limit = 1'b0;
        repeat (5) tick();
        check("tmo_still_opening", 8'(door_state), 8'd1);
        tick();
        check("tmo_fault_state", 8'(door_state), 8'd4);
        check("tmo_fault_flag", 8'(door_fault), 8'd1);
        check("tmo_motor_open", 8'(motor_open), 8'd0);
        check("tmo_closed_ok", 8'(door_closed_ok), 8'd0);
        closed_limit = 1'b1; fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("tmo_clear_state", 8'(door_state), 8'd0);
        check("tmo_clear_fault", 8'(door_fault), 8'd0);

        // emergency freeze mid-OPENING
        door_open_req = 1'b1;
        tick();
        door_open_req = 1'b0; closed_limit = 1'b0;
        tick(); tick();
        emergency_stop = 1'b1;
        tick();
        check("estop_motor_off", 8'(motor_open), 8'd0);
        check("estop_state", 8'(door_state), 8'd1);
        repeat (4) tick();
        check("estop_held_state", 8'(door_state), 8'd1);
        emergency_stop = 1'b0;
        tick();
        check("estop_resume_motor", 8'(motor_open), 8'd1);
        tick(); tick();
        check("estop_no_fault", 8'(door_state), 8'd1);
        open_limit = 1'b1;
        tick();
        check("estop_reach_open", 8'(door_state), 8'd2);

        // motion interlock fault in OPEN, then clear into CLOSING
        elevator_moving = 1'b1;
        tick();
        elevator_moving = 1'b0;
        check("moving_fault_state", 8'(door_state), 8'd4);
        check("moving_fault_flag", 8'(door_fault), 8'd1);
        open_limit = 1'b0; fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("clear_to_closing", 8'(door_state), 8'd3);
        check("clear_motor_close", 8'(motor_close), 8'd1);
        closed_limit = 1'b1;
        tick();
        check("clear_closed", 8'(door_state), 8'd0);

        // obstruction reopens twice, then nudge closing
        door_open_req = 1'b1;
        tick();
        door_open_req = 1'b0; closed_limit = 1'b0; open_limit = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            repeat (8) tick();
            check("obs_closing", 8'(door_state), 8'd3);
            check("obs_no_nudge", 8'(nudge), 8'd0);
            open_limit = 1'b0; obstruction = 1'b1;
            tick();
            check("obs_reopen", 8'(door_state), 8'd1);
            obstruction = 1'b0; open_limit = 1'b1;
            tick();
        end
        repeat (8) tick();
        check("nudge_closing", 8'(door_state), 8'd3);
        check("nudge_flag", 8'(nudge), 8'd1);
        check("nudge_motor_close", 8'(motor_close), 8'd1);
        open_limit = 1'b0; obstruction = 1'b1;
        tick(); tick();
        check("nudge_pause_state", 8'(door_state), 8'd3);
        check("nudge_pause_motor", 8'(motor_close), 8'd0);
        check("nudge_pause_flag", 8'(nudge), 8'd1);
        obstruction = 1'b0; door_open_req = 1'b1;
        tick();
        door_open_req = 1'b0;
        check("nudge_req_ignored", 8'(door_state), 8'd3);
        check("nudge_resume_motor", 8'(motor_close), 8'd1);
        closed_limit = 1'b1;
        tick();
        check("nudge_closed", 8'(door_state), 8'd0);
        check("nudge_cleared", 8'(nudge), 8'd0);

        // both limits active in CLOSED
        open_limit = 1'b1;
        tick();
        check("both_limits_fault", 8'(door_state), 8'd4);
        check("both_limits_closed_ok", 8'(door_closed_ok), 8'd0);
        open_limit = 1'b0; fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("both_limits_clear", 8'(door_state), 8'd0);

        // reset asserted mid-CLOSING
        door_open_req = 1'b1;
        tick();
        door_open_req = 1'b0; closed_limit = 1'b0; open_limit = 1'b1;
        tick();
        door_close_btn = 1'b1;
        tick();
        door_close_btn = 1'b0;
        tick();
        check("pre_reset_closing", 8'(motor_close), 8'd1);
        open_limit = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_motor", 8'(motor_close), 8'd0);
        check("async_rst_state", 8'(door_state), 8'd0);
        check("async_rst_closed_ok", 8'(door_closed_ok), 8'd0);
        closed_limit = 1'b1;
        #1;
        check("rst_closed_ok_follow", 8'(door_closed_ok), 8'd1);
        tick();
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
